// File: rtl/exec_ctrl_if.sv
// rtl/exec_ctrl_if.sv - instruction/register-file/ALU bus of exec_ctrl
// Signals: instr_valid/instr/instr_ready (instruction handshake),
//          rf_addr/rf_rdata (register-file read), alu_* (ALU request and result),
//          acc/flags/done/busy (architectural state and status),
//          illegal (only when EXEC_ILLEGAL_EN is defined).
// Modports: slave = exec_ctrl, master = the surrounding system.
interface exec_ctrl_if;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic [2:0] rf_addr;
    logic [7:0] rf_rdata;
    logic       alu_type;
    logic [3:0] alu_op;
    logic [7:0] alu_acc;
    logic [7:0] alu_reg;
    logic [7:0] alu_out;
    logic       alu_z;
    logic       alu_c;
    logic       alu_n;
    logic       alu_v;
    logic [7:0] acc;
    logic [3:0] flags;
    logic       done;
    logic       busy;
`ifdef EXEC_ILLEGAL_EN
    logic       illegal;
`endif

    modport slave (
        input  instr_valid, instr, rf_rdata, alu_out, alu_z, alu_c, alu_n, alu_v,
        output instr_ready, rf_addr, alu_type, alu_op, alu_acc, alu_reg,
`ifdef EXEC_ILLEGAL_EN
        output illegal,
`endif
        output acc, flags, done, busy
    );

    modport master (
        output instr_valid, instr, rf_rdata, alu_out, alu_z, alu_c, alu_n, alu_v,
        input  instr_ready, rf_addr, alu_type, alu_op, alu_acc, alu_reg,
`ifdef EXEC_ILLEGAL_EN
        input  illegal,
`endif
        input  acc, flags, done, busy
    );
endinterface

// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - three-state accumulator execution controller
// Ports: clk (rising edge), rst_n (async active-low), bus (exec_ctrl_if.slave).
// Instruction: bit 8 type, bits 7:4 OP, bit 3 ignored, bits 2:0 register index.
// Flags are ordered {z,c,n,v}. Fixed latency: handshake at edge T, writeback and
// done at edge T+2, next accept at edge T+3.
// Optional macro EXEC_ILLEGAL_EN adds bus.illegal, pulsed with done for illegal ops.
module exec_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    exec_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC} state_t;

    state_t     r_state;
    logic       r_type;
    logic [3:0] r_op;
    logic [2:0] r_rf_addr;
    logic [7:0] r_acc;
    logic [3:0] r_flags;
    logic       r_done;
    logic       r_busy;
    logic       r_ready;
    logic       r_alu_type;
    logic [3:0] r_alu_op;
    logic [7:0] r_alu_acc;
`ifdef EXEC_ILLEGAL_EN
    logic       r_illegal;
`endif

    logic w_arith;
    logic w_logic;
    logic w_cmp;
    logic w_mov;
    logic w_illegal;
    logic w_z;
    logic w_n;
    logic w_unused_rsvd;

    assign w_unused_rsvd = bus.instr[3];

    // Decode of the captured instruction, consumed at the EXEC->IDLE edge.
    always_comb begin
        w_arith   = 1'b0;
        w_logic   = 1'b0;
        w_cmp     = 1'b0;
        w_mov     = 1'b0;
        if (!r_type) begin
            w_arith = (r_op == 4'b0010) || (r_op == 4'b0011);
            w_logic = (r_op >= 4'b0100) && (r_op <= 4'b1000);
            w_cmp   = (r_op == 4'b1010);
        end else begin
            w_mov   = (r_op == 4'b0000);
        end
        w_illegal = !(w_arith || w_logic || w_cmp || w_mov);
    end

    assign w_z = (bus.alu_out == 8'h00);
    assign w_n = bus.alu_out[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_type     <= 1'b0;
            r_op       <= 4'b0000;
            r_rf_addr  <= 3'd0;
            r_acc      <= 8'h00;
            r_flags    <= 4'b0000;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_alu_type <= 1'b0;
            r_alu_op   <= 4'b0000;
            r_alu_acc  <= 8'h00;
`ifdef EXEC_ILLEGAL_EN
            r_illegal  <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
`ifdef EXEC_ILLEGAL_EN
            r_illegal <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // r_ready is always 1 in IDLE, so instr_valid alone is the handshake.
                    if (bus.instr_valid) begin
                        r_state   <= S_READ;
                        r_type    <= bus.instr[8];
                        r_op      <= bus.instr[7:4];
                        r_rf_addr <= bus.instr[2:0];
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b0;
                    end
                end
                S_READ: begin
                    // Register-file data arrives during EXEC; present the rest now.
                    r_state    <= S_EXEC;
                    r_alu_type <= r_type;
                    r_alu_op   <= r_op;
                    r_alu_acc  <= r_acc;
                end
                S_EXEC: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_ready    <= 1'b1;
                    r_done     <= 1'b1;
                    r_alu_type <= 1'b0;
                    r_alu_op   <= 4'b0000;
                    r_alu_acc  <= 8'h00;
`ifdef EXEC_ILLEGAL_EN
                    r_illegal  <= w_illegal;
`endif
                    if (w_arith) begin
                        r_acc   <= bus.alu_out;
                        r_flags <= {w_z, bus.alu_c, w_n, bus.alu_v};
                    end else if (w_logic) begin
                        r_acc   <= bus.alu_out;
                        r_flags <= {w_z, r_flags[2], w_n, r_flags[0]};
                    end else if (w_cmp) begin
                        r_flags <= {bus.alu_z, r_flags[2], bus.alu_n, r_flags[0]};
                    end else if (w_mov) begin
                        r_acc   <= bus.rf_rdata;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = r_ready;
    assign bus.rf_addr     = r_rf_addr;
    assign bus.alu_type    = r_alu_type;
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_acc     = r_alu_acc;
    // rf_rdata is only valid in EXEC, so this operand cannot be registered.
    assign bus.alu_reg     = (r_state == S_EXEC) ? bus.rf_rdata : 8'h00;
    assign bus.acc         = r_acc;
    assign bus.flags       = r_flags;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
`ifdef EXEC_ILLEGAL_EN
    assign bus.illegal     = r_illegal;
`endif
endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr  in  9  bit 8 type, bits 7:4 OP, bit 3 reserved, bits 2:0 register index.
REQ-006 instr_ready  out  1  block can accept an instruction.
REQ-007 rf_addr  out  3  register-file read index.
REQ-008 rf_rdata  in  8  register-file read data, valid one cycle after rf_addr.
REQ-009 alu_type, alu_op  out  1, 4  ALU type and OP.
REQ-010 alu_acc, alu_reg  out  8, 8  ALU operands.
REQ-011 alu_out  in  8  ALU result.
REQ-012 alu_z, alu_c, alu_n, alu_v  in  1 each  ALU flags.
REQ-013 acc  out  8  accumulator.
REQ-014 flags  out  4  {z,c,n,v}.
REQ-015 done  out  1  one-cycle retire pulse.
REQ-016 busy  out  1  high while not IDLE.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, READ and EXEC.
- IDLE: instr_ready=1.
- IDLE->READ when instr_valid&&instr_ready; instr captured; rf_addr=instr[2:0].
- READ->EXEC unconditionally.
- EXEC->IDLE unconditionally.
REQ-018 Latency SHALL be fixed: handshake at edge T, writeback and done=1 in the cycle after edge T+2, next accept possible at edge T+3.
REQ-019 In EXEC, the block SHALL drive alu_type/alu_op from the captured instr, alu_acc=acc and alu_reg=rf_rdata; outside EXEC alu_op=4'b0000 and operands=0.
REQ-020 Writeback at the EXEC->IDLE edge SHALL follow these rules (type=0):
- OP 0010/0011 ADD/SUB: acc<=alu_out; z,n from alu_out; c<=alu_c; v<=alu_v.
- OP 0100-1000 SHL/SHR/AND/OR/XOR: acc<=alu_out; z,n from alu_out; c,v unchanged.
- OP 1010 CMP: acc unchanged; z<=alu_z; n<=alu_n; c,v unchanged.
- Any other OP: illegal; acc and flags unchanged.
REQ-021 Type=1, OP 0000 (MOV) SHALL set acc<=rf_rdata with flags unchanged; other type=1 OPs are illegal.
REQ-022 z SHALL be 1 iff alu_out==8'h00, and n SHALL equal alu_out[7], for non-CMP writebacks.
REQ-023 Illegal instructions SHALL still take the full latency and pulse done.
REQ-024 instr_valid SHALL be ignored outside IDLE; instr changes after the handshake SHALL not affect execution.
REQ-025 The reserved bit instr[3] SHALL be ignored.

Reset
REQ-026 While rst_n=0: state=IDLE, acc=8'h00, flags=4'b0000, done=0, busy=0, instr_ready=1, rf_addr=0, alu outputs=0.
REQ-027 Reset asserted in READ or EXEC SHALL abort the instruction with no writeback and no done pulse.
REQ-028 After rst_n deasserts, an instruction SHALL be accepted at the first rising edge with instr_valid=1.

Configuration
REQ-029 With EXEC_ILLEGAL_EN defined, the block SHALL add an output illegal (1 bit), pulsed together with done for illegal instructions per REQ-020/021; its reset value is 0.
REQ-030 Without EXEC_ILLEGAL_EN, the illegal port SHALL be absent and illegal instructions SHALL retire silently as no-ops.

Verification
REQ-031 Reset, then MOV r1 (rf[1]=8'h05) -> acc=8'h05, flags=0000, done exactly 3 edges after the handshake.
REQ-032 acc=8'hFF, ADD r2 (rf[2]=8'h01, ALU returns 8'h00 with c=1) -> acc=8'h00, z=1, c=1, n=0.
REQ-033 acc=8'h03, CMP with rf=8'h07 (ALU z=0, n=1) -> acc stays 8'h03, z=0, n=1, c unchanged.
REQ-034 Back-to-back instr_valid held high -> handshakes every 3 cycles; instr_ready=0 in READ/EXEC.
REQ-035 rst_n pulsed low during EXEC of XOR -> acc=8'h00, no done, instr_ready=1.
REQ-036 type=0, OP=1111 with and without EXEC_ILLEGAL_EN -> acc/flags unchanged, done=1, illegal=1 only when defined.
